// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream and writes
// it word by word into instruction memory, holding the CPU in reset until a
// frame with a good checksum has been fully written.
//
// Frame: SYNC_BYTE, N (words), 4N data bytes (little-endian per word),
//        checksum = XOR of all data bytes.
//
// Ports:
//   clk            - sole clock, rising edge
//   reset          - synchronous, active-high reset
//   rx_data        - received byte
//   rx_valid       - rx_data holds a byte
//   rx_ready       - loader accepts a byte this cycle (low only when done)
//   imem_write     - one-cycle write strobe to instruction memory
//   imem_addr      - byte address of the written word (multiple of 4)
//   imem_writedata - written word
//   cpu_hold       - keeps the CPU in reset until the load completes
//   load_done      - program loaded and checksum good
//   load_error     - last frame rejected
module imem_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_write,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_writedata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [23:0] asm_q, asm_d;   // lanes 0..2; lane 3 comes straight from rx_data
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;

  assign rx_ready       = (state_q != S_DONE);
  assign cpu_hold       = (state_q != S_DONE);
  assign load_done      = (state_q == S_DONE);
  assign load_error     = (state_q == S_ERR);
  assign imem_write     = wr_q;
  assign imem_addr      = addr_q;
  assign imem_writedata = wdata_q;
  assign accept         = rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    chk_d      = chk_q;
    asm_d      = asm_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (accept && rx_data == SYNC_BYTE) state_d = S_LEN;
      end

      S_LEN: begin
        if (accept) begin
          if (rx_data == 8'h00 || 32'(rx_data) > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            len_d      = rx_data;
            word_idx_d = '0;
            byte_cnt_d = '0;
            chk_d      = '0;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              wr_d    = 1'b1;
              addr_d  = word_idx_q << 2;
              wdata_d = {rx_data, asm_q};
              // Index stays on the last word so it never exceeds MAX_WORDS-1.
              if (word_idx_q == len_q - 8'd1) state_d = S_CHK;
              else word_idx_d = word_idx_q + 8'd1;
            end
          endcase
        end
      end

      S_CHK: begin
        if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end

      S_DONE: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      chk_q      <= '0;
      asm_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      chk_q      <= chk_d;
      asm_q      <= asm_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_write;
  logic [7:0]  imem_addr;
  logic [31:0] imem_writedata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  imem_loader #(.SYNC_BYTE(8'hA5), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_write(imem_write), .imem_addr(imem_addr),
    .imem_writedata(imem_writedata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] words [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (imem_write !== 1'b0) begin
      if (exp_addr_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_write: got write addr %h data %h expected no write",
                 imem_addr, imem_writedata);
      end else begin
        check("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
        check("write_data", imem_writedata, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    bit ok;
    g = gaps ? int'($urandom_range(0, 5)) : 0;
    repeat (g) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      nchecks++;
      nerr++;
      $display("FAIL handshake_timeout: got rx_ready low for 20 cycles expected acceptance of %h", b);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_flags(input string tag, input bit done, input bit err);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'(!done));
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'(!done));
    check({tag, "_load_done"},  32'(load_done),  32'(done));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
  endtask

  // Reset for one edge, optionally with a byte presented on that same edge.
  task automatic do_reset(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = with_byte;
    rx_data  = b;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    check_flags("reset", 1'b0, 1'b0);
    check("reset_imem_write", 32'(imem_write), 32'd0);
    check("reset_imem_addr",  32'(imem_addr),  32'd0);
    check("reset_imem_data",  imem_writedata,  32'd0);
    reset = 1'b0;
  endtask

  // Reference: sends a frame built from words[0..n-1] and records the writes
  // the frame rules imply (only for legal lengths).
  task automatic run_frame(input int n, input bit good, input bit gaps, input bit sync);
    logic [7:0] chk;
    logic [7:0] by;
    if (sync) send_byte(8'hA5, gaps);
    send_byte(8'(n), gaps);
    if (n < 1 || n > 64) return;
    chk = 8'h00;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        by  = words[w][8*b +: 8];
        chk = chk ^ by;
        if (b == 3) begin
          exp_addr_q.push_back(8'(w * 4));
          exp_data_q.push_back(words[w]);
        end
        send_byte(by, gaps);
      end
    end
    send_byte(good ? chk : (chk ^ 8'hFF), gaps);
  endtask

  task automatic fixed_words();
    words[0] = 32'h00500013;
    words[1] = 32'h00100093;
  endtask

  task automatic random_words(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_done;
    bit good;
    int n;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset(1'b0, 8'h00);

    // Bad checksum: writes still happen, then ERR; resend recovers.
    fixed_words();
    run_frame(2, 1'b0, 1'b0, 1'b1);
    go_idle();
    check_flags("bad_chk", 1'b0, 1'b1);
    send_byte(8'hA5, 1'b0);
    go_idle();
    check("err_cleared_by_sync", 32'(load_error), 32'd0);
    check("err_sync_rx_ready", 32'(rx_ready), 32'd1);
    run_frame(2, 1'b1, 1'b0, 1'b0);
    go_idle();
    check_flags("resend_done", 1'b1, 1'b0);
    check("hold_addr", 32'(imem_addr), 32'h04);
    check("hold_data", imem_writedata, 32'h00100093);
    // Bytes offered in DONE are never accepted.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check_flags("done_sticky", 1'b1, 1'b0);

    // Illegal lengths.
    do_reset(1'b0, 8'h00);
    run_frame(0, 1'b1, 1'b0, 1'b1);
    go_idle();
    check_flags("len0", 1'b0, 1'b1);
    run_frame(65, 1'b1, 1'b0, 1'b1);
    go_idle();
    check_flags("len65", 1'b0, 1'b1);

    // Garbage before sync, then the frame with random gaps.
    do_reset(1'b0, 8'h00);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    go_idle();
    check_flags("garbage", 1'b0, 1'b0);
    fixed_words();
    run_frame(2, 1'b1, 1'b1, 1'b1);
    go_idle();
    check_flags("gaps_done", 1'b1, 1'b0);

    // Full-capacity frame.
    do_reset(1'b0, 8'h00);
    random_words(64);
    run_frame(64, 1'b1, 1'b1, 1'b1);
    go_idle();
    check_flags("max_done", 1'b1, 1'b0);
    check("max_last_addr", 32'(imem_addr), 32'hFC);

    // Reset after 6 data bytes: only word 0 written.
    do_reset(1'b0, 8'h00);
    random_words(2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        exp_addr_q.push_back(8'h00);
        exp_data_q.push_back(words[0]);
      end
      send_byte(words[i / 4][8*(i % 4) +: 8], 1'b0);
    end
    do_reset(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    random_words(2);
    run_frame(2, 1'b1, 1'b0, 1'b1);
    go_idle();
    check_flags("after_abort", 1'b1, 1'b0);

    // Reset coincident with acceptance of a word's 4th byte: no write.
    do_reset(1'b0, 8'h00);
    random_words(1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int b = 0; b < 3; b++) send_byte(words[0][8*b +: 8], 1'b0);
    do_reset(1'b1, words[0][31:24]);
    repeat (3) @(negedge clk);
    run_frame(1, 1'b1, 1'b0, 1'b1);
    go_idle();
    check_flags("after_edge_reset", 1'b1, 1'b0);

    // Random frames.
    prev_done = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (prev_done) do_reset(1'b0, 8'h00);
      n    = int'($urandom_range(1, 8));
      good = 1'($urandom_range(0, 1));
      random_words(n);
      run_frame(n, good, 1'($urandom_range(0, 1)), 1'b1);
      go_idle();
      check_flags("rand", good, !good);
      prev_done = good;
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter MAX_WORDS, default 64, instruction memory capacity in 32-bit words (256 bytes, 8-bit byte address).
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rx_data  input  8  received byte from serial receiver.
REQ-006 Port rx_valid  input  1  rx_data holds a byte.
REQ-007 Port rx_ready  output  1  loader accepts the byte this cycle.
REQ-008 Port imem_write  output  1  one-cycle write strobe to instruction memory.
REQ-009 Port imem_addr  output  8  byte address of the word written, always a multiple of 4.
REQ-010 Port imem_writedata  output  32  word written.
REQ-011 Port cpu_hold  output  1  high keeps the CPU in reset.
REQ-012 Port load_done  output  1  program loaded and checksum good.
REQ-013 Port load_error  output  1  last frame rejected.

Function
REQ-014 Byte accepted only on a cycle where rx_valid and rx_ready are both high; otherwise byte ignored and no state change.
REQ-015 Frame format: SYNC_BYTE, length N (words), 4N data bytes little-endian per word (first byte -> bits 7:0), checksum byte = XOR of all 4N data bytes.
REQ-016 States: IDLE, LEN, DATA, CHK, DONE, ERR.
REQ-017 IDLE: accepted SYNC_BYTE -> LEN; any other accepted byte discarded, stay IDLE.
REQ-018 LEN: accepted N with 1 <= N <= MAX_WORDS -> DATA, word index 0, byte count 0, checksum 0; N = 0 or N > MAX_WORDS -> ERR.
REQ-019 DATA: each accepted byte shifted into word assembly register at lane byte_count, XORed into checksum, byte_count increments modulo 4.
REQ-020 On acceptance of the 4th byte of a word, imem_write high for exactly the next cycle with imem_addr = word_index*4 (bits 7:0) and imem_writedata = assembled word; word_index then increments.
REQ-021 Write latency: 1 cycle from acceptance of the 4th byte to imem_write high; back-to-back words allowed (writes may occur on consecutive cycles only if bytes arrive every cycle; at most one write per 4 accepted bytes).
REQ-022 After the Nth word's 4th byte accepted -> CHK.
REQ-023 CHK: accepted byte equal to running checksum -> DONE; unequal -> ERR.
REQ-024 DONE: rx_ready low, cpu_hold low, load_done high; remains until reset.
REQ-025 ERR: load_error high, cpu_hold high, rx_ready high; accepted SYNC_BYTE -> LEN and load_error cleared on that transition; other bytes discarded.
REQ-026 Words written before an error are not rolled back; a new frame overwrites from address 0.
REQ-027 rx_ready high in IDLE, LEN, DATA, CHK, ERR; low only in DONE.
REQ-028 imem_write never high outside the cycle defined in REQ-020; imem_addr/imem_writedata hold last written values otherwise.
REQ-029 cpu_hold high in every state except DONE.
REQ-030 Word index never exceeds MAX_WORDS-1; address never wraps within a valid frame.

Reset
REQ-031 reset high at a rising edge: state IDLE, rx_ready 1, imem_write 0, imem_addr 8'h00, imem_writedata 32'h0, cpu_hold 1, load_done 0, load_error 0, counters and checksum 0.
REQ-032 reset mid-frame (any state) aborts immediately with REQ-031 values; no imem_write issued in the cycle after reset even if a 4th byte was accepted on the reset edge.
REQ-033 reset takes priority over a simultaneous handshake.

Verification
REQ-034 Frame A5,02,13,00,50,00,93,00,10,00,XOR=C0 -> writes addr 00 data 00500013, addr 04 data 00100093; then DONE, cpu_hold 0, load_done 1, rx_ready 0.
REQ-035 Same frame with checksum 00 -> both writes occur, then load_error 1, cpu_hold 1; resend correct frame -> load_error 0 after A5, ends in DONE.
REQ-036 Length byte 00 and 41 (65) -> ERR, no imem_write.
REQ-037 Garbage bytes 00,FF,12 before A5 -> ignored, frame then loads normally; rx_valid gaps of 0-5 cycles between bytes -> identical writes.
REQ-038 64-word frame -> last write addr FC, no address wrap, DONE.
REQ-039 reset asserted after 6 data bytes -> outputs at REQ-031 values next cycle, only one write (addr 00) ever observed; fresh frame loads from addr 00.
